// File: rtl/imem_boot_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_boot_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_e;

  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_BYTES      = 2;

endpackage

// File: rtl/byte_word_assembler.sv
// Packs accepted stream bytes little-endian into a 32-bit word.
// last_idx selects how many bytes make a word (1 -> 2-byte header, 3 -> data word).
// The word output already includes the byte being accepted, so the consumer can
// capture it in the same cycle word_valid pulses.
module byte_word_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        in_fire,
  input  logic [7:0]  in_byte,
  input  logic [1:0]  last_idx,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;

  // Insert the incoming byte at the current lane; wrap the counter after the last lane.
  always_comb begin
    cnt_d      = cnt_q;
    word_d     = word_q;
    word_valid = 1'b0;
    if (clr) begin
      cnt_d  = 2'd0;
      word_d = 32'd0;
    end else if (in_fire) begin
      word_d[{cnt_q, 3'b000} +: 8] = in_byte;
      if (cnt_q == last_idx) begin
        word_valid = 1'b1;
        cnt_d      = 2'd0;
      end else begin
        cnt_d = cnt_q + 2'd1;
      end
    end
  end

  assign word = word_d;

  // Byte counter and partial-word register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 2'd0;
      word_q <= 32'd0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed byte image, writes it into instruction
// memory from address 0 upward, and releases the core reset when the image is in.
module imem_boot_loader
  import imem_boot_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  input  logic [7:0]        BYTE_IN,
  input  logic              BYTE_VALID,
  output logic              BYTE_READY,
  output logic              IMEM_WE,
  output logic [ADDR_W-1:0] IMEM_ADDR,
  output logic [31:0]       IMEM_WDATA,
  output logic              CORE_RST,
  output logic              DONE,
  output logic              ERR
);

  localparam logic [31:0] CAPACITY = 32'd1 << ADDR_W;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]    n_q, n_d;
  logic [31:0]         wdata_q, wdata_d;

  logic                fire;
  logic                asm_clr;
  logic [1:0]          asm_last;
  logic                asm_valid;
  logic [31:0]         asm_word;
  logic [CNT_W-1:0]    hdr_n;

  assign BYTE_READY = (state_q == S_LEN) || (state_q == S_DATA);
  assign fire       = BYTE_VALID && BYTE_READY;
  assign asm_last   = (state_q == S_LEN) ? 2'(HDR_BYTES - 1) : 2'(BYTES_PER_WORD - 1);
  assign hdr_n      = asm_word[CNT_W-1:0];

  byte_word_assembler u_asm (
    .clk        (CLK),
    .rst_n      (RST),
    .clr        (asm_clr),
    .in_fire    (fire),
    .in_byte    (BYTE_IN),
    .last_idx   (asm_last),
    .word_valid (asm_valid),
    .word       (asm_word)
  );

  // Next-state logic; a (re)start clears the word index and the byte counter.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    n_d     = n_q;
    wdata_d = wdata_q;
    asm_clr = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (START) begin
          state_d = S_LEN;
          idx_d   = '0;
          asm_clr = 1'b1;
        end
      end
      S_LEN: begin
        if (asm_valid) begin
          n_d = hdr_n;
          if (hdr_n == '0)                 state_d = S_DONE;
          else if (32'(hdr_n) > CAPACITY)  state_d = S_ERR;
          else                             state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (asm_valid) begin
          wdata_d = asm_word;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (32'(idx_q) + 32'd1 == 32'(n_q)) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = S_DATA;
        end
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state, word index, header count and write-data registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      n_q     <= '0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      wdata_q <= wdata_d;
    end
  end

  assign IMEM_WE    = (state_q == S_WRITE);
  assign IMEM_ADDR  = idx_q;
  assign IMEM_WDATA = wdata_q;
  assign CORE_RST   = (state_q == S_DONE);
  assign DONE       = (state_q == S_DONE);
  assign ERR        = (state_q == S_ERR);

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized bench for imem_boot_loader: byte-level stimulus, expected writes
// derived from the image contents, and a per-cycle write checker.
module tb_imem_boot_loader;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic [7:0]  BYTE_IN;
  logic        BYTE_VALID;
  logic        BYTE_READY;
  logic        IMEM_WE;
  logic [7:0]  IMEM_ADDR;
  logic [31:0] IMEM_WDATA;
  logic        CORE_RST;
  logic        DONE;
  logic        ERR;

  imem_boot_loader #(.ADDR_W(8), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .START(START), .BYTE_IN(BYTE_IN), .BYTE_VALID(BYTE_VALID),
    .BYTE_READY(BYTE_READY), .IMEM_WE(IMEM_WE), .IMEM_ADDR(IMEM_ADDR),
    .IMEM_WDATA(IMEM_WDATA), .CORE_RST(CORE_RST), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] d;
  } wr_t;

  int          checks = 0;
  int          failures = 0;
  wr_t         exp_q[$];
  logic [31:0] exp_img [0:255];
  logic [31:0] mem     [0:255];
  logic [31:0] fix_w   [0:255];
  logic [31:0] saved   [0:2];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Instruction memory stand-in plus the per-cycle write checker.
  always @(negedge CLK) begin
    if (RST === 1'b1) begin
      if (IMEM_WE) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_we", {24'd0, IMEM_ADDR, IMEM_WDATA}, 64'd0);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("we_addr", 64'(IMEM_ADDR), 64'(e.a));
          chk("we_data", 64'(IMEM_WDATA), 64'(e.d));
        end
        chk("ready_in_write", 64'(BYTE_READY), 64'd0);
        mem[IMEM_ADDR] = IMEM_WDATA;
      end
      if (DONE) chk("done_core_rst", 64'(CORE_RST), 64'd1);
      if (ERR)  chk("err_outputs", {62'd0, CORE_RST, BYTE_READY}, 64'd0);
    end
  end

  task automatic check_reset(input string name);
    chk(name, {22'd0, BYTE_READY, IMEM_WE, IMEM_ADDR, IMEM_WDATA, CORE_RST, DONE, ERR}, 64'd0);
  endtask

  // One-cycle START; afterwards the loader must be collecting the header with the core held.
  task automatic pulse_start();
    @(negedge CLK); START = 1'b1;
    @(negedge CLK); START = 1'b0;
    chk("start_state", {61'd0, CORE_RST, DONE, BYTE_READY}, 64'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int g;
    int t;
    g = (gap == 0) ? 0 : int'($urandom_range(gap, 0));
    BYTE_VALID = 1'b0;
    repeat (g) begin BYTE_IN = 8'($urandom()); @(negedge CLK); end
    BYTE_VALID = 1'b1;
    BYTE_IN    = b;
    t = 0;
    while (!BYTE_READY && t < 50) begin @(negedge CLK); t++; end
    if (!BYTE_READY) begin
      chk("ready_timeout", 64'd0, 64'd1);
      BYTE_VALID = 1'b0;
      return;
    end
    @(negedge CLK);
    BYTE_VALID = 1'b0;
    BYTE_IN    = 8'($urandom());
  endtask

  // Build the byte image for n words, queue the expected writes, and stream it.
  task automatic load(input int n, input int gap, input bit fixed, input int start_at);
    logic [7:0]  bq[$];
    logic [31:0] w;
    logic [15:0] nn;
    nn = 16'(n);
    bq.push_back(nn[7:0]);
    bq.push_back(nn[15:8]);
    for (int i = 0; i < n; i++) begin
      w = fixed ? fix_w[i] : $urandom();
      exp_img[i] = w;
      exp_q.push_back('{a: 8'(i), d: w});
      for (int k = 0; k < 4; k++) bq.push_back(w[8*k +: 8]);
    end
    pulse_start();
    foreach (bq[j]) begin
      if (j == start_at) begin
        START = 1'b1; @(negedge CLK); START = 1'b0;
      end
      send_byte(bq[j], gap);
    end
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!DONE && t < 5000) begin @(negedge CLK); t++; end
    chk("done_reached", 64'(DONE), 64'd1);
    chk("pending_writes", 64'(exp_q.size()), 64'd0);
    chk("done_flags", {61'd0, CORE_RST, ERR, BYTE_READY}, 64'd4);
  endtask

  task automatic check_img(input int n);
    int bad;
    bad = -1;
    for (int i = n - 1; i >= 0; i--) if (mem[i] !== exp_img[i]) bad = i;
    chk("mem_image_first_bad", 64'(bad), {64{1'b1}});
  endtask

  initial begin
    RST = 1'b0; START = 1'b0; BYTE_IN = 8'd0; BYTE_VALID = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    repeat (3) @(negedge CLK);
    check_reset("reset_values");
    RST = 1'b1;
    @(negedge CLK);
    check_reset("idle_after_reset");

    // 1) two known words
    fix_w[0] = 32'h12345678;
    fix_w[1] = 32'hDEADBEEF;
    load(2, 0, 1'b1, -1);
    wait_done();
    chk("t1_word0", 64'(mem[0]), 64'h12345678);
    chk("t1_word1", 64'(mem[1]), 64'hDEADBEEF);

    // 2) empty image, reloaded from DONE
    load(0, 0, 1'b0, -1);
    wait_done();

    // 4) same image gapless and with random valid gaps
    for (int i = 0; i < 3; i++) fix_w[i] = $urandom();
    load(3, 0, 1'b1, -1);
    wait_done();
    for (int i = 0; i < 3; i++) begin saved[i] = mem[i]; mem[i] = 32'd0; end
    load(3, 3, 1'b1, -1);
    wait_done();
    chk("t4_same_image", {mem[0] ^ saved[0], mem[1] ^ saved[1]} | 64'(mem[2] ^ saved[2]), 64'd0);
    check_img(3);

    // full-capacity image: last address 255, no wrap
    load(256, 0, 1'b0, -1);
    wait_done();
    check_img(256);

    // 6) START in the middle of DATA is ignored
    load(2, 1, 1'b0, 5);
    wait_done();
    check_img(2);
    load(1, 0, 1'b0, -1);
    wait_done();
    check_img(1);

    // 3) oversize header 257 -> sticky error
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    @(negedge CLK);
    chk("t3_err", {60'd0, ERR, BYTE_READY, CORE_RST, DONE}, 64'h8);
    START = 1'b1; @(negedge CLK); START = 1'b0;
    repeat (2) @(negedge CLK);
    chk("t3_err_sticky", {60'd0, ERR, BYTE_READY, CORE_RST, DONE}, 64'h8);
    RST = 1'b0;
    @(negedge CLK);
    check_reset("t3_reset");
    RST = 1'b1;
    @(negedge CLK);

    // 5) reset in the middle of an N=4 load
    for (int i = 0; i < 4; i++) fix_w[i] = $urandom();
    exp_q.push_back('{a: 8'd0, d: fix_w[0]});
    pulse_start();
    send_byte(8'h04, 0);
    send_byte(8'h00, 0);
    for (int k = 0; k < 4; k++) send_byte(fix_w[0][8*k +: 8], 0);
    send_byte(fix_w[1][7:0], 0);
    #2 RST = 1'b0;
    #1 check_reset("t5_async_reset");
    chk("t5_word0_kept", 64'(mem[0]), 64'(fix_w[0]));
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    load(1, 1, 1'b0, -1);
    wait_done();
    check_img(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
